// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Purpose:
//   Scans a 4x4 active-low matrix keypad. One column is driven low per clk_en
//   tick; the rows are read back through a 2-FF synchronizer. The first key
//   found is debounced on press and on release, then reported as a 4-bit code
//   {row_idx, col_idx} with a one-clk key_valid strobe. key_held stays high
//   from the debounced press until the debounced release.
//
// Parameters:
//   DEBOUNCE_TICKS  clk_en ticks a key must be stable (press or release), >= 2
//   REPEAT_TICKS    clk_en ticks between auto-repeat strobes
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   clk_en     in   1  scan tick, one clk wide, period >= 4 clk
//   row        in   4  keypad rows, active-low, asynchronous (pulled up)
//   col        out  4  column drive, active-low one-hot (registered)
//   key_code   out  4  {row_idx, col_idx} of the last accepted key
//   key_valid  out  1  one-clk strobe: key_code newly valid
//   key_held   out  1  accepted key still held
//
// Build option:
//   KEYPAD_REPEAT_EN  when defined, a held key re-strobes key_valid every
//                     REPEAT_TICKS ticks. When undefined there is exactly one
//                     strobe per debounced press and no repeat logic.
//
// States:
//   state       | meaning
//   ST_SCAN     | walking the columns, waiting for any low row
//   ST_DEBOUNCE | column frozen, latched row bit must stay low
//   ST_PRESSED  | key accepted, waiting for the latched row bit to go high
//   ST_RELEASE  | latched row bit high, must stay high to end the press
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_TICKS = (DEBOUNCE_TICKS > REPEAT_TICKS) ? DEBOUNCE_TICKS
                                                             : REPEAT_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_TICKS - 1);
`endif

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_col;
  logic [1:0]       r_row_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  state_t           w_state_nxt;
  logic [1:0]       w_col_idx_nxt;
  logic [1:0]       w_row_idx_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_key_code_nxt;
  logic             w_key_valid_nxt;
  logic             w_key_held_nxt;

  logic [1:0]       w_first_row;
  logic             w_row_bit;
  logic [CNT_W-1:0] w_cnt_inc;

  function automatic logic [3:0] col_decode(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Lowest-numbered low row wins when several keys share the column.
  always_comb begin
    w_first_row = 2'd3;
    if (!r_row_sync[0]) begin
      w_first_row = 2'd0;
    end else if (!r_row_sync[1]) begin
      w_first_row = 2'd1;
    end else if (!r_row_sync[2]) begin
      w_first_row = 2'd2;
    end
  end

  // Only the latched row matters after detection; other rows are ignored
  // until scanning resumes.
  assign w_row_bit = r_row_sync[r_row_idx];

  // Saturating increment so a stuck count can never wrap into a false match.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_meta  <= 4'hF;
      r_row_sync  <= 4'hF;
      r_state     <= ST_SCAN;
      r_col_idx   <= 2'd0;
      r_col       <= 4'b1110;
      r_row_idx   <= 2'd0;
      r_cnt       <= CNT_ZERO;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_row_meta  <= row;
      r_row_sync  <= r_row_meta;
      r_state     <= w_state_nxt;
      r_col_idx   <= w_col_idx_nxt;
      r_col       <= col_decode(w_col_idx_nxt);
      r_row_idx   <= w_row_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
    end
  end

  // A detection tick counts as the first stable tick, so the press (or
  // release) is accepted on the tick where the incremented count reaches
  // DEBOUNCE_TICKS-1, i.e. after DEBOUNCE_TICKS consecutive stable ticks.
  always_comb begin
    w_state_nxt     = r_state;
    w_col_idx_nxt   = r_col_idx;
    w_row_idx_nxt   = r_row_idx;
    w_cnt_nxt       = r_cnt;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;

    if (clk_en) begin
      case (r_state)
        ST_SCAN: begin
          if (r_row_sync != 4'hF) begin
            w_row_idx_nxt = w_first_row;
            w_cnt_nxt     = CNT_ZERO;
            w_state_nxt   = ST_DEBOUNCE;
          end else begin
            w_col_idx_nxt = r_col_idx + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (!w_row_bit) begin
            if (w_cnt_inc == DB_LAST) begin
              w_state_nxt     = ST_PRESSED;
              w_cnt_nxt       = CNT_ZERO;
              w_key_code_nxt  = {r_row_idx, r_col_idx};
              w_key_valid_nxt = 1'b1;
              w_key_held_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            // Bounce: drop the candidate and move on to the next column.
            w_state_nxt   = ST_SCAN;
            w_col_idx_nxt = r_col_idx + 2'd1;
          end
        end

        ST_PRESSED: begin
          if (w_row_bit) begin
            w_state_nxt = ST_RELEASE;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (r_cnt == RP_LAST) begin
              w_key_valid_nxt = 1'b1;
              w_cnt_nxt       = CNT_ZERO;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
`else
            w_cnt_nxt = r_cnt;
`endif
          end
        end

        ST_RELEASE: begin
          if (w_row_bit) begin
            if (w_cnt_inc == DB_LAST) begin
              w_state_nxt    = ST_SCAN;
              w_cnt_nxt      = CNT_ZERO;
              w_key_held_nxt = 1'b0;
              w_col_idx_nxt  = r_col_idx + 2'd1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            // Key came back before the release settled: same press, no strobe.
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = CNT_ZERO;
          end
        end

        default: begin
          w_state_nxt = ST_SCAN;
        end
      endcase
    end
  end

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;
  int          n_vec = 0;
  int          n_err = 0;
  int          nvalid;

  typedef struct {
    logic [15:0] keys;
    int          ticks;
    logic [3:0]  col;
    logic        held;
    logic [3:0]  code;
    int          nvalid;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  keypad_scanner #(
    .DEBOUNCE_TICKS(4),
    .REPEAT_TICKS  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  function automatic logic [3:0] pad(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] res;
    res = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (k[r*4+cc] && !c[cc]) res[r] = 1'b0;
    return res;
  endfunction

  assign row = pad(keys, col);

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r*4 + c);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One scan tick = 4 clk; key_valid sampled on every clk of the tick.
  task automatic tick();
    @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    if (key_valid) nvalid++;
    repeat (2) begin
      @(negedge clk);
      if (key_valid) nvalid++;
    end
  endtask

  task automatic run_vec(input string name, input logic [15:0] k, input int t,
                         input logic [3:0] ecol, input logic eheld,
                         input logic [3:0] ecode, input int env);
    keys   = k;
    nvalid = 0;
    repeat (t) tick();
    n_vec++;
    chk({name, " col"},   int'(col),      int'(ecol));
    chk({name, " held"},  int'(key_held), int'(eheld));
    chk({name, " code"},  int'(key_code), int'(ecode));
    chk({name, " valid"}, nvalid,         env);
  endtask

  task automatic chk_reset_outputs(input string name);
    n_vec++;
    chk({name, " col"},   int'(col),       int'(4'b1110));
    chk({name, " valid"}, int'(key_valid), 0);
    chk({name, " held"},  int'(key_held),  0);
    chk({name, " code"},  int'(key_code),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    // scan walk after reset
    tbl[0]  = '{16'h0000, 1, 4'b1101, 1'b0, 4'h0, 0};
    tbl[1]  = '{16'h0000, 1, 4'b1011, 1'b0, 4'h0, 0};
    tbl[2]  = '{16'h0000, 1, 4'b0111, 1'b0, 4'h0, 0};
    tbl[3]  = '{16'h0000, 1, 4'b1110, 1'b0, 4'h0, 0};
    // row2/col1 press and release
    tbl[4]  = '{kbit(2,1), 10, 4'b1101, 1'b1, 4'b1001, 1};
    tbl[5]  = '{16'h0000,   5, 4'b1011, 1'b0, 4'b1001, 0};
    tbl[6]  = '{16'h0000,   1, 4'b0111, 1'b0, 4'b1001, 0};
    // bounce on row1/col0: low two ticks, then high
    tbl[7]  = '{kbit(1,0),  2, 4'b1110, 1'b0, 4'b1001, 0};
    tbl[8]  = '{16'h0000,   2, 4'b1101, 1'b0, 4'b1001, 0};
    tbl[9]  = '{16'h0000,   1, 4'b1011, 1'b0, 4'b1001, 0};
    // two keys in col3, lowest row wins; release row1, row3 picked up next
    tbl[10] = '{kbit(1,3) | kbit(3,3), 6, 4'b0111, 1'b1, 4'b0111, 1};
    tbl[11] = '{kbit(3,3),  5, 4'b1110, 1'b0, 4'b0111, 0};
    tbl[12] = '{kbit(3,3),  7, 4'b0111, 1'b1, 4'b1111, 1};
    tbl[13] = '{16'h0000,   5, 4'b1110, 1'b0, 4'b1111, 0};

    keys   = 16'h0000;
    clk_en = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("reset");

    for (int i = 0; i < 14; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].keys, tbl[i].ticks, tbl[i].col,
              tbl[i].held, tbl[i].code, tbl[i].nvalid);
    end

    // reset while a key is accepted and still held
    run_vec("pre_reset_press", kbit(0,2), 6, 4'b1011, 1'b1, 4'b0010, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_outputs("mid_reset");
    run_vec("reaccept", kbit(0,2), 6, 4'b1011, 1'b1, 4'b0010, 1);
    run_vec("reaccept_release", 16'h0000, 5, 4'b0111, 1'b0, 4'b0010, 0);

    // long hold on row0/col0: accepted at the 5th tick, repeats at +8 ticks
`ifdef KEYPAD_REPEAT_EN
    run_vec("long_hold", kbit(0,0), 40, 4'b1110, 1'b1, 4'b0000, 5);
`else
    run_vec("long_hold", kbit(0,0), 40, 4'b1110, 1'b1, 4'b0000, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
